cls_hex_formatter: RTL and testbench

CLS_HEX_FORMATTER -- requirements
Module: cls_hex_formatter

---
 rtl/cls_hex_formatter.sv | 105 ++++++++++
 tb/tb_cls_hex_formatter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/cls_hex_formatter.sv
// cls_hex_formatter: formats a 32-bit value as an ASCII hex byte stream for a PmodCLS display.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - synchronous active-high reset, dominates all inputs
//   start      - request to format data (accepted only in IDLE)
//   data       - 32-bit value, latched on start acceptance
//   byte_data  - byte toward the SPI byte sender (0x00 when no byte is offered)
//   byte_valid - byte_data holds a byte to transfer
//   byte_ready - downstream accepts byte_data this cycle
//   busy       - high from start acceptance through the DONE cycle
//   done       - one-cycle pulse after the final transfer
//
// Build option: define CLS_HEX_PREFIX_EN to emit "0x" between the clear
// escape and the digits (13 bytes instead of 11).
module cls_hex_formatter (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] data,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic        done
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] DIGIT = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
`ifdef CLS_HEX_PREFIX_EN
    localparam logic [2:0] PREFIX      = 3'd2;
    localparam logic [2:0] AFTER_CLEAR = PREFIX;
`else
    localparam logic [2:0] AFTER_CLEAR = DIGIT;
`endif

    logic [2:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] val_q, val_d;
    logic [31:0] shifted;
    logic [3:0]  nib;
    logic [7:0]  ascii;
    logic        last;

    // Current digit: shift the selected nibble up to the top of the word.
    assign shifted = val_q << {idx_q[2:0], 2'b00};
    assign nib     = shifted[31:28];
    assign ascii   = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
    assign busy    = state_q != IDLE;
    assign done    = state_q == DONE;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        val_d      = val_q;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        last       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    val_d   = data;
                end
            end
            CLEAR: begin
                byte_valid = 1'b1;
                byte_data  = (idx_q == 4'd0) ? 8'h1B : (idx_q == 4'd1) ? 8'h5B : 8'h6A;
                last       = idx_q == 4'd2;
            end
`ifdef CLS_HEX_PREFIX_EN
            PREFIX: begin
                byte_valid = 1'b1;
                byte_data  = (idx_q == 4'd0) ? 8'h30 : 8'h78;
                last       = idx_q == 4'd1;
            end
`endif
            DIGIT: begin
                byte_valid = 1'b1;
                byte_data  = ascii;
                last       = idx_q == 4'd7;
            end
            default: state_d = IDLE;
        endcase
        // Advance only on an actual transfer; the index restarts at each state change.
        if (byte_valid && byte_ready) begin
            idx_d = last ? 4'd0 : idx_q + 4'd1;
            if (last)
                state_d = (state_q == CLEAR) ? AFTER_CLEAR : (state_q == DIGIT) ? DONE : DIGIT;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            val_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
        end
    end
endmodule

// File: tb/tb_cls_hex_formatter.sv
// tb_cls_hex_formatter: self-checking bench for cls_hex_formatter against a string-based model.
module tb_cls_hex_formatter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] data = 32'd0;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready = 1'b0;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

`ifdef CLS_HEX_PREFIX_EN
    localparam int NB = 13;
`else
    localparam int NB = 11;
`endif

    cls_hex_formatter dut (
        .clock(clock), .reset(reset), .start(start), .data(data),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected byte stream: clear/home escape, optional "0x", then the value as uppercase hex text.
    task automatic build(input logic [31:0] d);
        string s;
        s = $sformatf("%08h", d);
        s = s.toupper();
        exp_q = '{8'h1B, 8'h5B, 8'h6A};
`ifdef CLS_HEX_PREFIX_EN
        exp_q.push_back("0");
        exp_q.push_back("x");
`endif
        for (int i = 0; i < 8; i++) exp_q.push_back(s[i]);
    endtask

    // rmode: 0 ready always high, 1 ready toggles 1/0, 2 random ready.
    // poke: cycle index at which a spurious start with 0xFFFFFFFF is driven (-1 none).
    task automatic run(input logic [31:0] d, input int rmode, input int poke, input bit started);
        int n = 0;
        int cyc = 0;
        int stalls = 0;
        logic [7:0] held = 8'h00;
        bit prev_stall = 1'b0;
        build(d);
        if (!started) begin
            start = 1'b1;
            data  = d;
            @(negedge clock);
        end
        start = 1'b0;
        while (!done && cyc < 100) begin
            chk("busy", {31'd0, busy}, 32'd1);
            chk("valid", {31'd0, byte_valid}, 32'd1);
            chk("byte", {24'd0, byte_data}, (n < exp_q.size()) ? {24'd0, exp_q[n]} : 32'd0);
            if (prev_stall) chk("hold", {24'd0, byte_data}, {24'd0, held});
            start = (cyc == poke);
            if (start) data = 32'hFFFF_FFFF;
            byte_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            prev_stall = !byte_ready;
            held = byte_data;
            if (byte_ready) n++;
            else stalls++;
            cyc++;
            @(negedge clock);
        end
        start = 1'b0;
        chk("done", {31'd0, done}, 32'd1);
        chk("count", n, NB);
        chk("latency", cyc, NB + stalls);
        chk("done_valid", {31'd0, byte_valid}, 32'd0);
        byte_ready = 1'($urandom_range(0, 1));
        @(negedge clock);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_valid", {31'd0, byte_valid}, 32'd0);
    endtask

    initial begin
        // Reset dominates start and byte_ready.
        start = 1'b1;
        data = 32'h1234_5678;
        byte_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_valid", {31'd0, byte_valid}, 32'd0);
        chk("rst_data", {24'd0, byte_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        chk("idle_after_rst", {31'd0, busy}, 32'd0);

        run(32'h89AB_CDEF, 0, -1, 1'b0);
        run(32'h0000_0000, 0, -1, 1'b0);
        run(32'h1234_5678, 1, -1, 1'b0);
        run(32'h1357_9BDF, 0, 2, 1'b0);

        // Reset while the fifth byte is offered.
        build(32'hCAFE_F00D);
        start = 1'b1;
        data = 32'hCAFE_F00D;
        byte_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        chk("b5_data", {24'd0, byte_data}, {24'd0, exp_q[4]});
        reset = 1'b1;
        start = 1'b1;
        @(negedge clock);
        chk("abort_valid", {31'd0, byte_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_data", {24'd0, byte_data}, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clock);
        chk("abort_quiet", {31'd0, byte_valid}, 32'd0);
        run(32'hDEAD_BEEF, 0, -1, 1'b0);

        // start held high: one IDLE cycle between DONE and the next acceptance.
        build(32'hA5A5_0F0F);
        start = 1'b1;
        data = 32'hA5A5_0F0F;
        byte_ready = 1'b1;
        @(negedge clock);
        for (int k = 0; k < NB; k++) begin
            chk("b2b_byte", {24'd0, byte_data}, {24'd0, exp_q[k]});
            @(negedge clock);
        end
        chk("b2b_done", {31'd0, done}, 32'd1);
        data = 32'h0123_4567;
        @(negedge clock);
        chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
        chk("b2b_idle_valid", {31'd0, byte_valid}, 32'd0);
        @(negedge clock);
        run(32'h0123_4567, 0, -1, 1'b1);

        for (int r = 0; r < 6; r++) run($urandom, 2, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
